dc303_svc: RTL and testbench

- Service status word collector upstream of the DC303 control chip.
- Synchronizes asynchronous board-level requests and latches pulsed error events into sticky flags.
- Stretches power-up DCLO, then presents a 13-bit service word that the control chip samples on its RNI cycles.
- Output updates only on master falling-edge enables, so the word is stable whenever the control chip samples on the rising-edge enable.

---
 rtl/dc303_svc.sv | 108 ++++++++++
 tb/tb_dc303_svc.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dc303_svc.sv
// Service status word collector for the DC303 control chip.
// Synchronizes async requests, latches error pulses, stretches DCLO, publishes pin_svc on mce_n.
module dc303_svc #(
  parameter int SYNC_LEN = 2,
  parameter int DCLO_DLY = 8
) (
  input  logic        pin_clk,
  input  logic        pin_rst,
  input  logic        pin_mce_p,
  input  logic        pin_mce_n,
  input  logic        pin_evnt,
  input  logic [3:0]  pin_irq,
  input  logic        pin_aclo,
  input  logic        pin_dclo,
  input  logic        pin_halt,
  input  logic        pin_cerr,
  input  logic        pin_mmu,
  input  logic        pin_par,
  input  logic        pin_bto,
  input  logic        pin_sclr,
  input  logic [3:0]  pin_smsk,
  output logic [12:0] pin_svc
);

  localparam logic [7:0]  DCNT_INIT = 8'(DCLO_DLY);
  localparam logic [12:0] SVC_INIT  = 13'o00201;

  // Async bundle layout: [0] evnt, [4:1] irq7..4, [5] aclo, [6] dclo, [7] halt
  logic [7:0]  async_s;
  logic [7:0]  sync_r [SYNC_LEN];
  logic [7:0]  synced_s;
  logic        evnt_prev_r;
  logic        evnt_f_s;
  logic        mce_n_s;
  logic [3:0]  sticky_r;
  logic [3:0]  sticky_set_s;
  logic [3:0]  sticky_clr_s;
  logic [3:0]  sticky_nxt_s;
  logic [7:0]  dcnt_r;
  logic [7:0]  dcnt_nxt_s;
  logic        dclo_o_s;
  logic [12:0] svc_r;
  logic [12:0] svc_nxt_s;

  assign async_s  = {pin_halt, pin_dclo, pin_aclo, pin_irq, pin_evnt};
  assign synced_s = sync_r[SYNC_LEN-1];

  // An overlapping mce_p turns the falling-edge enable off; that combination is illegal anyway.
  assign mce_n_s  = pin_mce_n & ~pin_mce_p;
  assign evnt_f_s = synced_s[0] & ~evnt_prev_r;

  // Sticky bits: [0] event, [1] timeout, [2] parity, [3] MMU, matching pin_smsk.
  assign sticky_set_s = {pin_mmu, pin_par, pin_bto, evnt_f_s};
  assign sticky_clr_s = {4{mce_n_s & pin_sclr}} & pin_smsk;
  assign sticky_nxt_s = (sticky_r & ~sticky_clr_s) | sticky_set_s;

  assign dclo_o_s = synced_s[6] | (dcnt_r != 8'd0);

  // Synchronizer chain for all asynchronous inputs
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      for (int i = 0; i < SYNC_LEN; i++) sync_r[i] <= 8'h00;
    end else begin
      sync_r[0] <= async_s;
      for (int i = 1; i < SYNC_LEN; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // DCLO stretch counter next value; saturates at zero
  always_comb begin
    dcnt_nxt_s = dcnt_r;
    if (synced_s[6]) begin
      dcnt_nxt_s = DCNT_INIT;
    end else if (mce_n_s && (dcnt_r != 8'd0)) begin
      dcnt_nxt_s = dcnt_r - 8'd1;
    end else begin
      dcnt_nxt_s = dcnt_r;
    end
  end

  // Status word as presented to the control chip; several bits are active-low
  always_comb begin
    svc_nxt_s = {sticky_r[0], synced_s[4:1], ~synced_s[5], 1'b0, synced_s[7],
                 ~pin_cerr, ~sticky_r[3], ~sticky_r[2], sticky_r[1], dclo_o_s};
  end

  // State registers and output word
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      evnt_prev_r <= 1'b0;
      sticky_r    <= 4'h0;
      dcnt_r      <= DCNT_INIT;
      svc_r       <= SVC_INIT;
    end else begin
      evnt_prev_r <= synced_s[0];
      sticky_r    <= sticky_nxt_s;
      dcnt_r      <= dcnt_nxt_s;
      if (mce_n_s) begin
        svc_r <= svc_nxt_s;
      end else begin
        svc_r <= svc_r;
      end
    end
  end

  assign pin_svc = svc_r;

endmodule

// File: tb/tb_dc303_svc.sv
// Self-checking bench for dc303_svc: directed scenarios plus random traffic,
// every cycle compared against a history-based reference model.
module tb_dc303_svc;

  localparam int SL = 3;
  localparam int DD = 8;

  logic        clk = 1'b0;
  logic        rst, mce_p, mce_n, evnt, aclo, dclo, halt, cerr, mmu, par, bto, sclr;
  logic [3:0]  irq, smsk;
  logic [12:0] svc;

  int total = 0;
  int bad   = 0;

  // Reference model: input history (hist[k] = inputs k+1 cycles back), sticky bits, counter, word
  logic [7:0]  hist [0:SL];
  logic [3:0]  m_st;
  int          m_dcnt;
  logic [12:0] m_svc;

  always #5 clk = ~clk;

  dc303_svc #(.SYNC_LEN(SL), .DCLO_DLY(DD)) dut (
    .pin_clk (clk),
    .pin_rst (rst),
    .pin_mce_p(mce_p),
    .pin_mce_n(mce_n),
    .pin_evnt(evnt),
    .pin_irq (irq),
    .pin_aclo(aclo),
    .pin_dclo(dclo),
    .pin_halt(halt),
    .pin_cerr(cerr),
    .pin_mmu (mmu),
    .pin_par (par),
    .pin_bto (bto),
    .pin_sclr(sclr),
    .pin_smsk(smsk),
    .pin_svc (svc)
  );

  always @(posedge clk) begin
    assert (!(mce_p && mce_n)) else $error("illegal mce_p/mce_n overlap");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [7:0] cur, sy, pv;
    logic       evf, dclo_o;
    logic [3:0] clr, set;
    cur = {halt, dclo, aclo, irq, evnt};
    if (rst) begin
      m_st   = 4'h0;
      m_dcnt = DD;
      m_svc  = 13'o00201;
      for (int i = 0; i <= SL; i++) hist[i] = 8'h00;
    end else begin
      sy     = hist[SL-1];
      pv     = hist[SL];
      evf    = sy[0] && !pv[0];
      dclo_o = sy[6] || (m_dcnt > 0);
      if (mce_n)
        m_svc = {m_st[0], sy[4:1], !sy[5], 1'b0, sy[7], !cerr, !m_st[3], !m_st[2], m_st[1], dclo_o};
      clr  = (mce_n && sclr) ? smsk : 4'h0;
      set  = {mmu, par, bto, evf};
      m_st = (m_st & ~clr) | set;
      if (sy[6]) m_dcnt = DD;
      else if (mce_n && m_dcnt > 0) m_dcnt = m_dcnt - 1;
      for (int i = SL; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = cur;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("svc", {19'd0, svc}, {19'd0, m_svc});
  endtask

  // n cycles with mce_n on every second clock
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      mce_n = ~mce_n;
      cycle();
    end
  endtask

  task automatic one(input logic en);
    mce_n = en;
    cycle();
  endtask

  int n_en, n_hi;

  initial begin
    rst = 1'b1; mce_p = 1'b0; mce_n = 1'b0; evnt = 1'b0; aclo = 1'b0; dclo = 1'b0;
    halt = 1'b0; cerr = 1'b0; mmu = 1'b0; par = 1'b0; bto = 1'b0; sclr = 1'b0;
    irq = 4'h0; smsk = 4'h0;
    cycle();
    cycle();
    chk("rst_val", {19'd0, svc}, 32'o00201);

    // Power-up DCLO stretch
    rst = 1'b0;
    n_en = 0; n_hi = 0;
    for (int i = 0; i < 40; i++) begin
      one(i % 2 == 1);
      if (mce_n) begin
        n_en++;
        if (svc[0]) n_hi++;
      end
    end
    chk("dclo_stretch", n_hi, DD);
    chk("settled", {19'd0, svc}, 32'o00234);

    // Timer event: sticky, merged, cleared, and set-wins collision
    evnt = 1'b1; run(50);
    chk("ev_set", svc[12], 1);
    evnt = 1'b0; run(6);
    evnt = 1'b1; run(10);
    chk("ev_merge", svc[12], 1);
    sclr = 1'b1; smsk = 4'b0001; one(1'b1);
    sclr = 1'b0; one(1'b0); one(1'b1);
    chk("ev_clr", svc[12], 0);
    evnt = 1'b0; for (int i = 0; i < 6; i++) one(1'b0);
    evnt = 1'b1; one(1'b0); one(1'b0); one(1'b0);
    sclr = 1'b1; one(1'b1);
    sclr = 1'b0; one(1'b0); one(1'b1);
    chk("ev_collide", svc[12], 1);

    // Bus timeout: set, wrong mask, right mask
    bto = 1'b1; one(1'b0); bto = 1'b0; one(1'b1);
    chk("bto_set", svc[1], 1);
    sclr = 1'b1; smsk = 4'b0100; one(1'b1); sclr = 1'b0; one(1'b0); one(1'b1);
    chk("bto_hold", svc[1], 1);
    sclr = 1'b1; smsk = 4'b0010; one(1'b1); sclr = 1'b0; one(1'b0); one(1'b1);
    chk("bto_clr", svc[1], 0);

    // Parity and MMU together
    par = 1'b1; mmu = 1'b1; one(1'b0); par = 1'b0; mmu = 1'b0; one(1'b1);
    chk("parmmu_set", svc[3:2], 0);
    sclr = 1'b1; smsk = 4'b1100; one(1'b1); sclr = 1'b0; one(1'b0); one(1'b1);
    chk("parmmu_clr", svc[3:2], 3);

    // IRQ synchronizer latency and hold while mce_n is low
    irq = 4'b1010; one(1'b0); one(1'b0); one(1'b1);
    chk("irq_early", svc[11:8], 0);
    one(1'b0); one(1'b1);
    chk("irq_seen", svc[11:8], 4'b1010);
    irq = 4'b0101;
    for (int i = 0; i < 6; i++) one(1'b0);
    chk("irq_hold", svc[11:8], 4'b1010);
    irq = 4'h0; run(10);

    // DCLO pulse, then reset mid-stretch with a pending sticky flag
    dclo = 1'b1; one(1'b0); dclo = 1'b0; run(40);
    dclo = 1'b1; one(1'b0); dclo = 1'b0; bto = 1'b1; one(1'b1); bto = 1'b0; run(9);
    rst = 1'b1; one(1'b0); rst = 1'b0;
    chk("rst_mid", {19'd0, svc}, 32'o00201);
    run(40);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      mce_n = ($urandom_range(2) == 0);
      mce_p = !mce_n && ($urandom_range(1) == 1);
      if ($urandom_range(7) == 0)  evnt = ~evnt;
      if ($urandom_range(15) == 0) irq = 4'($urandom);
      if ($urandom_range(31) == 0) aclo = ~aclo;
      if ($urandom_range(31) == 0) halt = ~halt;
      if ($urandom_range(3) == 0)  cerr = ~cerr;
      bto  = ($urandom_range(15) == 0);
      par  = ($urandom_range(15) == 0);
      mmu  = ($urandom_range(15) == 0);
      sclr = ($urandom_range(3) == 0);
      smsk = 4'($urandom);
      dclo = ($urandom_range(63) == 0);
      rst  = ($urandom_range(199) == 0);
      cycle();
    end
    mce_p = 1'b0;
    rst   = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
